// File: rtl/teclado_pin_tx.sv
// teclado_pin_tx: keypad-side PIN transmitter.
// Sends a 16-bit PIN as four digit strobes (MSB nibble first), then waits for
// the PIN checker's verdict and reports it as a one-cycle result pulse.
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   enviar, pin_in[15:0]        start request and PIN, sampled in IDLE only
//   pin_incorrecto, advertencia,
//   bloqueo, fin                checker verdict / status inputs
//   digito_stb, digito[3:0]     one-cycle digit strobe and value
//   ocupado                     transaction in progress
//   resultado_vld, resultado    verdict pulse and held code
//                               (00 ok, 01 rejected, 10 locked, 11 timeout)
//   aviso                       sticky warning seen during this transaction
module teclado_pin_tx #(
  parameter int unsigned GAP     = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enviar,
  input  logic [15:0] pin_in,
  input  logic        pin_incorrecto,
  input  logic        advertencia,
  input  logic        bloqueo,
  input  logic        fin,
  output logic        digito_stb,
  output logic [3:0]  digito,
  output logic        ocupado,
  output logic        resultado_vld,
  output logic [1:0]  resultado,
  output logic        aviso
);

  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB,
    S_GAP,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t        state, state_d;
  logic [15:0]   shift, shift_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic [1:0]    dig_cnt, dig_cnt_d;
  logic          dig_done, dig_done_d;
  logic [1:0]    code, code_d;
  logic          digito_stb_d;
  logic [3:0]    digito_d;
  logic          ocupado_d;
  logic          resultado_vld_d;
  logic [1:0]    resultado_d;
  logic          aviso_d;
  logic          last_dig;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d         = state;
    shift_d         = shift;
    gap_cnt_d       = gap_cnt;
    tmo_cnt_d       = tmo_cnt;
    dig_cnt_d       = dig_cnt;
    dig_done_d      = dig_done;
    code_d          = code;
    digito_stb_d    = 1'b0;
    digito_d        = 4'h0;
    ocupado_d       = ocupado;
    resultado_vld_d = 1'b0;
    resultado_d     = resultado;
    aviso_d         = aviso | (advertencia && (state != S_IDLE));
    last_dig        = (dig_cnt == 2'd3);

    case (state)
      S_IDLE: begin
        if (enviar) begin
          shift_d     = pin_in;
          ocupado_d   = 1'b1;
          aviso_d     = 1'b0;
          resultado_d = 2'b00;
          dig_cnt_d   = 2'd0;
          dig_done_d  = 1'b0;
          state_d     = S_STB;
        end
      end
      S_STB: begin
        digito_stb_d = 1'b1;
        digito_d     = shift[15:12];
        shift_d      = {shift[11:0], 4'h0};
        gap_cnt_d    = '0;
        tmo_cnt_d    = '0;
        // Digit counter saturates at the 4th digit; done flag steers to WAIT.
        dig_done_d   = last_dig;
        dig_cnt_d    = last_dig ? dig_cnt : dig_cnt + 2'd1;
        state_d      = (last_dig || dig_done) ? S_WAIT : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          state_d = S_STB;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      S_WAIT: begin
        // Verdict priority: locked > accepted > rejected > timeout.
        if (bloqueo) begin
          code_d  = 2'b10;
          state_d = S_REPORT;
        end else if (fin) begin
          code_d  = 2'b00;
          state_d = S_REPORT;
        end else if (pin_incorrecto) begin
          code_d  = 2'b01;
          state_d = S_REPORT;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          code_d  = 2'b11;
          state_d = S_REPORT;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      S_REPORT: begin
        resultado_vld_d = 1'b1;
        resultado_d     = code;
        ocupado_d       = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      shift         <= 16'h0;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
      dig_cnt       <= 2'd0;
      dig_done      <= 1'b0;
      code          <= 2'b00;
      digito_stb    <= 1'b0;
      digito        <= 4'h0;
      ocupado       <= 1'b0;
      resultado_vld <= 1'b0;
      resultado     <= 2'b00;
      aviso         <= 1'b0;
    end else begin
      state         <= state_d;
      shift         <= shift_d;
      gap_cnt       <= gap_cnt_d;
      tmo_cnt       <= tmo_cnt_d;
      dig_cnt       <= dig_cnt_d;
      dig_done      <= dig_done_d;
      code          <= code_d;
      digito_stb    <= digito_stb_d;
      digito        <= digito_d;
      ocupado       <= ocupado_d;
      resultado_vld <= resultado_vld_d;
      resultado     <= resultado_d;
      aviso         <= aviso_d;
    end
  end

endmodule
